// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register and instruction-fetch sequencer feeding decode/control.
// Optional IFU_FETCH_COUNT_EN adds a consumed-instruction counter on fetch_count.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        PC_Src,
  input  logic [31:0] pc_target,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misalign_fault
`ifdef IFU_FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t state;

  logic consume;
  logic bad_target;

  assign imem_addr  = pc;
  assign pc_plus4   = pc + 32'd4;
  assign consume    = (state == HOLD) && !stall;
  assign bad_target = PC_Src && (pc_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_VECTOR;
      instr          <= NOP_INSTR;
      instr_valid    <= 1'b0;
      imem_req       <= 1'b0;
      misalign_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (consume) begin
            instr_valid <= 1'b0;
            if (bad_target) begin
              // pc keeps the address of the faulting branch for post-mortem
              misalign_fault <= 1'b1;
              state          <= FAULT;
            end else begin
              pc       <= PC_Src ? pc_target : pc_plus4;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        FAULT: begin
          state          <= FAULT;
          imem_req       <= 1'b0;
          instr_valid    <= 1'b0;
          misalign_fault <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_FETCH_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'd0;
    end else if (consume) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit (memory driver, monitor, directed flow).
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        PC_Src;
  logic [31:0] pc_target;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        misalign_fault;
`ifdef IFU_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .PC_Src         (PC_Src),
    .pc_target      (pc_target),
    .instr          (instr),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .instr_valid    (instr_valid),
    .misalign_fault (misalign_fault)
`ifdef IFU_FETCH_COUNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec;
  int          n_err;
  logic        ready_en;
  logic [31:0] exp_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    return a ^ 32'hDEAD_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: answers a pending request just after the falling edge
  initial begin
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && imem_req && ready_en) begin
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
        sb_q.push_back('{addr: imem_addr, data: mem_word(imem_addr)});
      end else begin
        imem_ready = 1'b0;
      end
    end
  end

  // Monitor: every new instr_valid assertion must match the oldest issued fetch
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && !prev) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_empty: instr %08h pc %08h with no fetch outstanding", instr, pc);
        end else begin
          e = sb_q.pop_front();
          check("sb_instr", instr, e.data);
          check("sb_pc", pc, e.addr);
        end
      end
      prev = instr_valid;
    end
  end

  task automatic wait_valid();
    int i;
    for (i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
    if (!instr_valid) check("valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic consume(input logic src, input logic [31:0] tgt);
    wait_valid();
    stall     = 1'b0;
    PC_Src    = src;
    pc_target = tgt;
    exp_count = exp_count + 32'd1;
    @(negedge clk);
    stall  = 1'b1;
    PC_Src = 1'b0;
  endtask

  task automatic advance_to(input logic [31:0] target);
    int i;
    wait_valid();
    for (i = 0; i < 32 && pc != target; i++) begin
      consume(1'b0, 32'd0);
      wait_valid();
    end
    check("advance_pc", pc, target);
  endtask

  task automatic check_count();
`ifdef IFU_FETCH_COUNT_EN
    check("fetch_count", fetch_count, exp_count);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_fault"}, 32'(misalign_fault), 32'd0);
  endtask

  // Called at a falling edge; reset asserts between edges to exercise the async path
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    exp_count = 32'd0;
    #1;
    check_reset_values(tag);
    check_count();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_fetch_req"}, 32'(imem_req), 32'd1);
    check({tag, "_fetch_addr"}, imem_addr, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    stall     = 1'b0;
    PC_Src    = 1'b0;
    pc_target = 32'd0;
    ready_en  = 1'b1;
    exp_count = 32'd0;

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    check("reset_pc_plus4", pc_plus4, 32'h4);
    check_count();

    // Free run: ready always, no stall, sequential
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("run_valid", 32'(instr_valid), 32'(i % 2 == 0));
      check("run_req", 32'(imem_req), 32'(i % 2));
      if (i % 2 == 1) check("run_addr", imem_addr, 32'(4 * (i / 2)));
    end
    stall     = 1'b1;
    exp_count = 32'd2;
    check_count();

    // Memory wait states at pc=0x10
    advance_to(32'hC);
    ready_en = 1'b0;
    consume(1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("wait_addr", imem_addr, 32'h10);
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    ready_en = 1'b1;
    @(negedge clk);
    check("wait_instr", instr, 32'h0050_0093);
    check("wait_valid_after", 32'(instr_valid), 32'd1);

    // Stall overrides a pending redirect
    advance_to(32'h20);
    PC_Src    = 1'b1;
    pc_target = 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pc", pc, 32'h20);
      check("stall_pc_plus4", pc_plus4, 32'h24);
      check("stall_valid", 32'(instr_valid), 32'd1);
    end
    consume(1'b1, 32'h40);
    check("redir_addr", imem_addr, 32'h40);
    check("redir_req", 32'(imem_req), 32'd1);
    check_count();

    // Misaligned redirect faults and sticks
    consume(1'b1, 32'h30);
    wait_valid();
    check("pre_fault_pc", pc, 32'h30);
    consume(1'b1, 32'h46);
    check_count();
    for (int i = 0; i < 10; i++) begin
      check("fault_flag", 32'(misalign_fault), 32'd1);
      check("fault_pc", pc, 32'h30);
      check("fault_req", 32'(imem_req), 32'd0);
      check("fault_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    do_reset("fault_clr");

    // pc wraps past the top of the address space
    consume(1'b1, 32'hFFFF_FFFC);
    wait_valid();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    consume(1'b0, 32'd0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_req", 32'(imem_req), 32'd1);
    check_count();

    // Reset while a response is being presented in FETCH
    consume(1'b0, 32'd0);
    check("midfetch_addr", imem_addr, 32'h4);
    do_reset("midfetch");
    wait_valid();
    check("post_reset_pc", pc, 32'h0);
    @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
